// File: rtl/flag_branch_unit_if.sv
// Bus bundle between the fetch/ALU side and the flag/branch unit.
// The master drives ALU flags and branch requests; the slave returns pc and control pulses.
interface flag_branch_unit_if;
  logic        alu_valid;
  logic        alu_zero;
  logic        alu_sign;
  logic        alu_carry;
  logic        alu_carry_we;
  logic        pc_en;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_op;
  logic [31:0] br_target;
  logic [31:0] br_pc;
  logic [31:0] pc;
  logic        stall;
  logic        flush;
  logic        link_we;
  logic [31:0] link_data;
  logic [2:0]  flags;
  logic        misalign_err;

  modport master (
    output alu_valid, alu_zero, alu_sign, alu_carry, alu_carry_we,
    output pc_en, br_valid, br_op, br_target, br_pc,
    input  br_ready, pc, stall, flush, link_we, link_data, flags, misalign_err
  );

  modport slave (
    input  alu_valid, alu_zero, alu_sign, alu_carry, alu_carry_we,
    input  pc_en, br_valid, br_op, br_target, br_pc,
    output br_ready, pc, stall, flush, link_we, link_data, flags, misalign_err
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Flag register plus fetch PC and conditional branch resolution.
// A branch takes RUN -> RESOLVE -> FLUSH (if taken and aligned) -> RUN.
module flag_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  flag_branch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } stateT;

  localparam logic [2:0] OP_B    = 3'd0;
  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_BLTZ = 3'd2;
  localparam logic [2:0] OP_BZ   = 3'd3;
  localparam logic [2:0] OP_BNZ  = 3'd4;
  localparam logic [2:0] OP_BL   = 3'd5;
  localparam logic [2:0] OP_BCY  = 3'd6;
  localparam logic [2:0] OP_BNCY = 3'd7;

  stateT       state;
  stateT       nextState;
  logic [2:0]  opQ;
  logic [31:0] targetQ;
  logic [31:0] brPcQ;
  logic [31:0] pcQ;
  logic [2:0]  flagsQ;
  logic        misalignQ;
  logic        handshake;
  logic        taken;
  logic        aligned;
  logic        redirect;
  logic        linkWe;

  assign handshake = bus.br_valid && (state == RUN);
  assign aligned   = (targetQ[1:0] == 2'b00);
  assign redirect  = (state == RESOLVE) && taken && aligned;

  // Condition is judged on the registered flags {carry, sign, zero}.
  always_comb begin
    taken = 1'b0;
    case (opQ)
      OP_B, OP_BR, OP_BL: taken = 1'b1;
      OP_BLTZ:            taken = flagsQ[1];
      OP_BZ:              taken = flagsQ[0];
      OP_BNZ:             taken = !flagsQ[0];
      OP_BCY:             taken = flagsQ[2];
      OP_BNCY:            taken = !flagsQ[2];
      default:            taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (handshake) nextState = RESOLVE;
      RESOLVE: nextState = (taken && aligned) ? FLUSH : RUN;
      FLUSH:   nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  // Link write is masked by rst so a reset mid-RESOLVE never commits the return address.
  always_comb begin
    bus.br_ready = (state == RUN);
    bus.stall    = (state != RUN);
    bus.flush    = (state == FLUSH);
    linkWe       = (state == RESOLVE) && (opQ == OP_BL) && aligned && !rst;
    bus.link_we  = linkWe;
    bus.link_data = linkWe ? (brPcQ + 32'd4) : 32'h0000_0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opQ     <= OP_B;
      targetQ <= 32'h0000_0000;
      brPcQ   <= 32'h0000_0000;
    end else if (handshake) begin
      opQ     <= bus.br_op;
      targetQ <= bus.br_target;
      brPcQ   <= bus.br_pc;
    end
  end

  // Flags follow the ALU in every state; carry only on ops that produce one.
  always_ff @(posedge clk) begin
    if (rst) begin
      flagsQ <= 3'b000;
    end else if (bus.alu_valid) begin
      flagsQ[0] <= bus.alu_zero;
      flagsQ[1] <= bus.alu_sign;
      if (bus.alu_carry_we) flagsQ[2] <= bus.alu_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcQ       <= RESET_PC;
      misalignQ <= 1'b0;
    end else begin
      if ((state == RUN) && bus.pc_en) pcQ <= pcQ + 32'd4;
      else if (redirect)               pcQ <= targetQ;
      if ((state == RESOLVE) && taken && !aligned) misalignQ <= 1'b1;
    end
  end

  assign bus.pc           = pcQ;
  assign bus.flags        = flagsQ;
  assign bus.misalign_err = misalignQ;

endmodule
